uart_tx_fifo: RTL and testbench

//   Buffered 8N1 UART transmitter: bytes pushed on a valid/ready port are queued in a FIFO and serialised LSB-first onto uart_tx.

---
 rtl/uart_tx_fifo.sv | 167 ++++++++++++++++
 tb/tb_uart_tx_fifo.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: buffered 8N1 UART transmitter.
//   Bytes accepted on a valid/ready port are queued in a FIFO and sent
//   LSB-first with one start and one stop bit. A new frame starts directly
//   after the previous stop bit when data is waiting and ena is high.
// Ports:
//   clk         chip clock, all state on rising edge
//   rst_n       asynchronous active-low reset
//   ena         allows new frames to start (sampled at frame-start decisions)
//   tx_data     byte to enqueue
//   tx_valid    tx_data valid this cycle
//   tx_ready    FIFO not full; push = tx_valid & tx_ready
//   uart_tx     registered serial line, idle high
//   busy        frame in progress
//   fifo_count  bytes queued, excluding the byte being shifted
//   overflow    sticky, tx_valid seen while tx_ready was low
module uart_tx_fifo #(
  parameter int CLKS_PER_BIT = 87,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          ena,
  input  logic [7:0]                    tx_data,
  input  logic                          tx_valid,
  output logic                          tx_ready,
  output logic                          uart_tx,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [AW:0]   DEPTH_C  = (AW+1)'(FIFO_DEPTH);
  localparam logic [AW:0]   COUNT_1  = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_1    = AW'(1);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_1    = CW'(1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t          state, state_d;
  logic [CW-1:0]   bit_cnt, bit_cnt_d;
  logic [2:0]      bit_idx, bit_idx_d;
  logic [7:0]      shift, shift_d;
  logic            tx_d;
  logic            pop;
  logic            push;
  logic            last_bit;

  logic [7:0]      mem [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;

  assign tx_ready = (fifo_count != DEPTH_C);
  assign push     = tx_valid & tx_ready;
  assign busy     = (state != IDLE);
  assign last_bit = (bit_cnt == CNT_LAST);

  // Storage has no reset; validity is tracked entirely by the pointers/count.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= tx_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      overflow   <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_1;
      if (pop)  rd_ptr <= rd_ptr + PTR_1;
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + COUNT_1;
        2'b01:   fifo_count <= fifo_count - COUNT_1;
        default: fifo_count <= fifo_count;
      endcase
      if (tx_valid && !tx_ready) overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      bit_cnt <= '0;
      bit_idx <= '0;
      shift   <= '0;
      uart_tx <= 1'b1;
    end else begin
      state   <= state_d;
      bit_cnt <= bit_cnt_d;
      bit_idx <= bit_idx_d;
      shift   <= shift_d;
      uart_tx <= tx_d;
    end
  end

  // tx_d is the line level for the cycle following this edge, so the
  // registered uart_tx always matches the state it was loaded with.
  always_comb begin
    state_d   = state;
    bit_cnt_d = bit_cnt;
    bit_idx_d = bit_idx;
    shift_d   = shift;
    tx_d      = uart_tx;
    pop       = 1'b0;
    case (state)
      IDLE: begin
        tx_d = 1'b1;
        if (ena && fifo_count != '0) begin
          pop       = 1'b1;
          shift_d   = mem[rd_ptr];
          state_d   = START;
          bit_cnt_d = '0;
          tx_d      = 1'b0;
        end
      end
      START: begin
        if (last_bit) begin
          state_d   = DATA;
          bit_cnt_d = '0;
          bit_idx_d = '0;
          tx_d      = shift[0];
        end else begin
          bit_cnt_d = bit_cnt + CNT_1;
        end
      end
      DATA: begin
        if (last_bit) begin
          bit_cnt_d = '0;
          if (bit_idx == 3'd7) begin
            state_d = STOP;
            tx_d    = 1'b1;
          end else begin
            shift_d   = {1'b0, shift[7:1]};
            bit_idx_d = bit_idx + 3'd1;
            tx_d      = shift[1];
          end
        end else begin
          bit_cnt_d = bit_cnt + CNT_1;
        end
      end
      STOP: begin
        if (last_bit) begin
          bit_cnt_d = '0;
          if (ena && fifo_count != '0) begin
            // back-to-back frame: no idle cycle after the stop bit
            pop     = 1'b1;
            shift_d = mem[rd_ptr];
            state_d = START;
            tx_d    = 1'b0;
          end else begin
            state_d = IDLE;
            tx_d    = 1'b1;
          end
        end else begin
          bit_cnt_d = bit_cnt + CNT_1;
        end
      end
      default: begin
        state_d = IDLE;
        tx_d    = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Testbench for uart_tx_fifo (CLKS_PER_BIT = 4, FIFO_DEPTH = 4).
// A transaction-level model (byte queue + frame-remaining cycle count)
// predicts status outputs and the line level each cycle; accepted bytes are
// pushed to a scoreboard which a line-decoding monitor pops from.
module tb_uart_tx_fifo;

  localparam int CPB   = 4;
  localparam int DEPTH = 4;
  localparam int FRAME = 10 * CPB;

  logic       clk;
  logic       rst_n;
  logic       ena;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       uart_tx;
  logic       busy;
  logic [2:0] fifo_count;
  logic       overflow;

  uart_tx_fifo #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .uart_tx(uart_tx), .busy(busy), .fifo_count(fifo_count),
    .overflow(overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  // reference model
  logic [7:0] mq[$];
  logic [7:0] expq[$];
  logic [7:0] cur = 8'h00;
  int         rem = 0;
  bit         movf = 0;

  function automatic int line_m();
    int p;
    if (rem == 0) return 1;
    p = (FRAME - rem) / CPB;
    if (p == 0) return 0;
    if (p == 9) return 1;
    return int'(cur[p-1]);
  endfunction

  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        mq.delete();
        expq.delete();
        rem  = 0;
        movf = 0;
      end else begin
        int sz;
        bit acc;
        sz  = mq.size();
        acc = tx_valid && (sz < DEPTH);
        if (tx_valid && !acc) movf = 1;
        if (ena && sz != 0 && rem <= 1) begin
          cur = mq.pop_front();
          rem = FRAME;
        end else if (rem > 0) begin
          rem--;
        end
        if (acc) begin
          mq.push_back(tx_data);
          expq.push_back(tx_data);
        end
      end
    end
  end

  // per-cycle status checks
  bit started = 0;
  always @(negedge clk) begin
    if (started) begin
      check("tx_ready", int'(tx_ready), (mq.size() < DEPTH) ? 1 : 0);
      check("fifo_count", int'(fifo_count), mq.size());
      check("busy", int'(busy), (rem != 0) ? 1 : 0);
      check("overflow", int'(overflow), int'(movf));
      check("uart_tx", int'(uart_tx), line_m());
    end
  end

  // line monitor: decode frames and compare against the scoreboard
  bit          in_frame = 0;
  int          ns = 0;
  logic [39:0] samp;
  int          frames_seen = 0;
  always @(negedge clk) begin
    if (!rst_n) begin
      in_frame = 0;
      ns = 0;
    end else if (started) begin
      if (!in_frame && uart_tx == 1'b0) begin
        in_frame = 1;
        ns = 0;
      end
      if (in_frame) begin
        samp[ns] = uart_tx;
        ns++;
        if (ns == FRAME) begin
          logic [7:0] b;
          bit stable;
          stable = 1;
          for (int i = 0; i < 10; i++)
            for (int j = 1; j < CPB; j++)
              if (samp[i*CPB+j] != samp[i*CPB]) stable = 0;
          for (int i = 0; i < 8; i++) b[i] = samp[(i+1)*CPB];
          check("bit_width_stable", int'(stable), 1);
          check("start_bit", int'(samp[0]), 0);
          check("stop_bit", int'(samp[9*CPB]), 1);
          if (expq.size() == 0) begin
            check("unexpected_frame", 1, 0);
          end else begin
            check("frame_byte", int'(b), int'(expq.pop_front()));
          end
          frames_seen++;
          in_frame = 0;
        end
      end
    end
  end

  task automatic cyc(input bit v, input logic [7:0] d);
    tx_valid = v;
    tx_data  = d;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    tx_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int f0;
    rst_n = 1'b0; ena = 1'b1; tx_valid = 1'b0; tx_data = 8'h00;
    repeat (2) @(negedge clk);
    check("reset_uart_tx", int'(uart_tx), 1);
    check("reset_tx_ready", int'(tx_ready), 1);
    check("reset_busy", int'(busy), 0);
    check("reset_fifo_count", int'(fifo_count), 0);
    check("reset_overflow", int'(overflow), 0);
    rst_n = 1'b1;
    started = 1;
    @(negedge clk);

    // single byte
    cyc(1, 8'hA5);
    idle(FRAME + 10);

    // back-to-back frames
    f0 = frames_seen;
    cyc(1, 8'h00); cyc(1, 8'hFF); cyc(1, 8'h55);
    idle(3 * FRAME + 10);
    check("burst_frames", frames_seen - f0, 3);

    // ena held low: fill, overflow, then release
    ena = 1'b0;
    for (int i = 0; i < 5; i++) cyc(1, 8'($urandom));
    idle(10);
    f0 = frames_seen;
    ena = 1'b1;
    idle(4 * FRAME + 10);
    check("gated_frames", frames_seen - f0, 4);

    // drop ena mid-frame with bytes queued
    cyc(1, 8'($urandom)); cyc(1, 8'($urandom)); cyc(1, 8'($urandom));
    idle(12);
    ena = 1'b0;
    idle(2 * FRAME);
    ena = 1'b1;
    idle(2 * FRAME + 10);

    // async reset mid-frame with overflow set
    ena = 1'b0;
    for (int i = 0; i < 5; i++) cyc(1, 8'($urandom));
    ena = 1'b1;
    idle(15);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midreset_uart_tx", int'(uart_tx), 1);
    check("midreset_busy", int'(busy), 0);
    check("midreset_fifo_count", int'(fifo_count), 0);
    check("midreset_overflow", int'(overflow), 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    idle(3);

    // random traffic, exercises pointer wrap
    for (int i = 0; i < 600; i++) begin
      if (i % 25 == 0) ena = ($urandom_range(0, 5) != 0);
      cyc($urandom_range(0, 2) == 0, 8'($urandom));
    end

    // drain
    ena = 1'b1;
    tx_valid = 1'b0;
    begin
      bit done;
      done = 0;
      for (int i = 0; i < 2000 && !done; i++) begin
        @(negedge clk);
        if (rem == 0 && mq.size() == 0 && !in_frame) done = 1;
      end
      check("drain_done", int'(done), 1);
    end
    idle(2);
    check("scoreboard_empty", expq.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
